// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding is 2-bit; GRANT_* values are what last_grant holds.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin tie-break: one-hot grant, bit0 = I port, bit1 = D port.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_i && req_d) begin
            grant = (last_grant == GRANT_D) ? 2'b01 : 2'b10;
        end else begin
            grant = {req_d, req_i};
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache block requests onto one memory port.
// Latency: 1 cycle to mem_* asserted, memory latency, then 1 idle bubble.
// Backpressure: mem_* held stable until mem_ready; losing port simply waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t     state;
    logic       last_grant;
    logic       d_req;
    logic [1:0] grant;

    assign d_req = d_read | d_write;

    rr_arb2 u_rr_arb2 (
        .req_i      (i_read),
        .req_d      (d_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Read data is broadcast; the per-port ready is the only qualifier.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign i_ready = (state == S_SERVE_I) && mem_ready;
    assign d_ready = (state == S_SERVE_D) && mem_ready;

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state      <= S_IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last_grant <= GRANT_D;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant[0]) begin
                        state     <= S_SERVE_I;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
                        mem_addr  <= i_addr;
                    end else if (grant[1]) begin
                        // A simultaneous read+write is taken as a write.
                        state     <= S_SERVE_D;
                        mem_read  <= ~d_write;
                        mem_write <= d_write;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                end
                S_SERVE_I: begin
                    if (mem_ready) begin
                        state      <= S_IDLE;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        last_grant <= GRANT_I;
                    end
                end
                S_SERVE_D: begin
                    if (mem_ready) begin
                        state      <= S_IDLE;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        last_grant <= GRANT_D;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         i_read, d_read, d_write, mem_ready;
    logic [27:0]  i_addr, d_addr, mem_addr;
    logic [127:0] d_wdata, mem_wdata, mem_rdata, i_rdata, d_rdata;
    logic         i_ready, d_ready, mem_read, mem_write;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] PAT_A5 = {16{8'hA5}};

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_ready    (i_ready),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        mem_ready = 1'b0;
        i_addr    = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        proc_reset = 1'b1;
        step();
        step();
        proc_reset = 1'b0;
    endtask

    task automatic test_reset();
        proc_reset = 1'b1;
        i_read  = 1'b1;
        d_write = 1'b1;
        i_addr  = 28'h1234567;
        d_addr  = 28'h7654321;
        d_wdata = {4{$urandom}};
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_err++; $display("FAIL reset_rw: got %b want 00", {mem_read, mem_write});
        end
        n_vec++;
        if (mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            n_err++; $display("FAIL reset_addr_data: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        n_vec++;
        if ({i_ready, d_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_ready: got %b want 00", {i_ready, d_ready});
        end
        step();
        proc_reset = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_i_read();
        int hold_cnt = 0, i_cnt = 0, d_cnt = 0;
        logic [127:0] got = '0;
        do_reset();
        i_read = 1'b1;
        i_addr = 28'h0000010;
        @(negedge clk);
        n_vec++;
        if (mem_read !== 1'b0) begin
            n_err++; $display("FAIL iread_latency: mem_read got %b want 0 before edge", mem_read);
        end
        step();
        i_read = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h0000010) begin
            n_err++; $display("FAIL iread_issue: got rd=%b wr=%b addr=%h want 1 0 0000010",
                              mem_read, mem_write, mem_addr);
        end
        for (int c = 0; c < 8; c++) begin
            mem_ready = (c == 3);
            mem_rdata = (c == 3) ? PAT_A5 : {4{$urandom}};
            @(negedge clk);
            if (mem_read === 1'b1 && mem_addr === 28'h0000010) hold_cnt++;
            if (i_ready === 1'b1) begin i_cnt++; got = i_rdata; end
            if (d_ready !== 1'b0) d_cnt++;
            step();
        end
        mem_ready = 1'b0;
        n_vec++;
        if (hold_cnt != 4) begin
            n_err++; $display("FAIL iread_hold: got %0d cycles want 4", hold_cnt);
        end
        n_vec++;
        if (i_cnt != 1 || got !== PAT_A5) begin
            n_err++; $display("FAIL iread_ready: got %0d pulses data %h want 1 pulse %h", i_cnt, got, PAT_A5);
        end
        n_vec++;
        if (d_cnt != 0) begin
            n_err++; $display("FAIL iread_dready: got %0d d_ready cycles want 0", d_cnt);
        end
    endtask

    task automatic test_d_write();
        do_reset();
        d_write = 1'b1;
        d_addr  = 28'h0000020;
        d_wdata = 128'h1234;
        step();
        d_write = 1'b0;
        d_addr  = 28'hFFFFFFF;
        d_wdata = {4{$urandom}};
        i_read  = 1'b1;
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== 128'h1234 || mem_addr !== 28'h0000020) begin
            n_err++; $display("FAIL dwrite_issue: got wr=%b rd=%b data=%h addr=%h want 1 0 1234 0000020",
                              mem_write, mem_read, mem_wdata, mem_addr);
        end
        n_vec++;
        if ({d_ready, i_ready} !== 2'b10) begin
            n_err++; $display("FAIL dwrite_ready: got d/i=%b want 10", {d_ready, i_ready});
        end
        step();
        mem_ready = 1'b0;
        i_read    = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_read, mem_write, d_ready} !== 3'b000) begin
            n_err++; $display("FAIL dwrite_idle: got rd/wr/dr=%b want 000", {mem_read, mem_write, d_ready});
        end
    endtask

    task automatic test_round_robin();
        int got_q[$];
        bit prev_rdy = 1'b0;
        bit no_bubble = 1'b0;
        clear_inputs();
        proc_reset = 1'b1;
        i_read = 1'b1;
        d_read = 1'b1;
        i_addr = 28'h0000100;
        d_addr = 28'h0000200;
        step();
        proc_reset = 1'b0;
        for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
            mem_ready = mem_read | mem_write;
            @(negedge clk);
            if (i_ready === 1'b1) got_q.push_back(1);
            if (d_ready === 1'b1) got_q.push_back(2);
            if ((i_ready | d_ready) && prev_rdy) no_bubble = 1'b1;
            prev_rdy = i_ready | d_ready;
            step();
        end
        clear_inputs();
        n_vec++;
        if (got_q.size() != 4) begin
            n_err++; $display("FAIL rr_count: got %0d grants want 4", got_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (k >= got_q.size() || got_q[k] != ((k % 2 == 0) ? 1 : 2)) begin
                n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k,
                                  (k < got_q.size()) ? got_q[k] : 0, (k % 2 == 0) ? 1 : 2);
            end
        end
        n_vec++;
        if (no_bubble) begin
            n_err++; $display("FAIL rr_bubble: got back-to-back ready want idle bubble");
        end
        step();
    endtask

    task automatic test_rw_both();
        logic [127:0] wd;
        do_reset();
        wd = {$urandom, $urandom, $urandom, $urandom};
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 28'h0ABCDEF;
        d_wdata = wd;
        step();
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== wd) begin
            n_err++; $display("FAIL rw_both: got wr=%b rd=%b data=%h want 1 0 %h", mem_write, mem_read, mem_wdata, wd);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_read = 1'b1;
        d_addr = 28'h0000040;
        step();
        d_read = 1'b0;
        step();
        proc_reset = 1'b1;
        step();
        proc_reset = 1'b0;
        mem_ready  = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({mem_read, mem_write, d_ready, i_ready} !== 4'b0000) begin
            n_err++; $display("FAIL rstmid_drop: got rd/wr/dr/ir=%b want 0000", {mem_read, mem_write, d_ready, i_ready});
        end
        step();
        mem_ready = 1'b0;
        i_read = 1'b1;
        i_addr = 28'h0000044;
        step();
        i_read = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000044) begin
            n_err++; $display("FAIL rstmid_idle: got rd=%b addr=%h want 1 0000044", mem_read, mem_addr);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_spurious_ready();
        int bad = 0;
        do_reset();
        d_write = 1'b1;
        d_addr  = 28'h0000777;
        d_wdata = 128'hCAFE;
        step();
        clear_inputs();
        mem_ready = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1;
            mem_rdata = {4{$urandom}};
            @(negedge clk);
            n_vec++;
            if ({i_ready, d_ready, mem_read, mem_write} !== 4'b0000 ||
                mem_addr !== 28'h0000777 || mem_wdata !== 128'hCAFE) begin
                n_err++; bad++;
                $display("FAIL spurious[%0d]: got ir/dr/rd/wr=%b addr=%h data=%h want 0000 0000777 cafe",
                         c, {i_ready, d_ready, mem_read, mem_write}, mem_addr, mem_wdata);
            end
            step();
        end
        mem_ready = 1'b0;
    endtask

    // Transaction-level reference: who owns memory, what request it carries.
    task automatic test_random();
        int           owner = 0;  // 0 none, 1 I, 2 D
        int           last = 2;
        logic         e_rd = 1'b0, e_wr = 1'b0;
        logic [27:0]  e_addr = '0;
        logic [127:0] e_wdata = '0;
        int           pick;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            proc_reset = ($urandom_range(0, 99) == 0);
            i_read     = ($urandom_range(0, 2) != 0);
            d_read     = $urandom_range(0, 1) == 1;
            d_write    = ($urandom_range(0, 3) == 0);
            i_addr     = 28'($urandom);
            d_addr     = 28'($urandom);
            d_wdata    = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
            mem_ready  = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            n_vec++;
            if (i_ready !== (owner == 1 && mem_ready) || d_ready !== (owner == 2 && mem_ready)) begin
                n_err++; $display("FAIL rand_ready[%0d]: got i/d=%b%b want %b%b", c, i_ready, d_ready,
                                  owner == 1 && mem_ready, owner == 2 && mem_ready);
            end
            n_vec++;
            if (i_rdata !== mem_rdata || d_rdata !== mem_rdata) begin
                n_err++; $display("FAIL rand_rdata[%0d]: got %h/%h want %h", c, i_rdata, d_rdata, mem_rdata);
            end
            n_vec++;
            if (mem_read !== e_rd || mem_write !== e_wr || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
                n_err++; $display("FAIL rand_mem[%0d]: got %b%b %h %h want %b%b %h %h", c, mem_read, mem_write,
                                  mem_addr, mem_wdata, e_rd, e_wr, e_addr, e_wdata);
            end
            if (proc_reset) begin
                owner = 0; last = 2; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
            end else if (owner == 0) begin
                if (i_read && (d_read || d_write)) pick = (last == 2) ? 1 : 2;
                else if (i_read)                   pick = 1;
                else if (d_read || d_write)        pick = 2;
                else                               pick = 0;
                if (pick == 1) begin
                    owner = 1; e_rd = 1; e_wr = 0; e_addr = i_addr;
                end else if (pick == 2) begin
                    owner = 2; e_wr = d_write; e_rd = !d_write; e_addr = d_addr; e_wdata = d_wdata;
                end
            end else if (mem_ready) begin
                e_rd = 0; e_wr = 0; last = owner; owner = 0;
            end
            step();
        end
        proc_reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        proc_reset = 1'b1;
        clear_inputs();
        step();
        test_reset();
        test_i_read();
        test_d_write();
        test_round_robin();
        test_rw_both();
        test_reset_mid();
        test_spurious_ready();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
